// File: rtl/cla_serial_sub.sv
// Multi-cycle WIDTH-bit subtractor: d = a - b - bin, one 4-bit carry-lookahead
// slice per clock, least significant slice first, with a registered borrow chain.
module cla_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  localparam int SLICES = WIDTH / 4;
  localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and once out_valid rises the result
  // is held until out_ready is seen.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;

  logic [3:0]       x, y, g, p, s;
  logic [4:0]       c;
  logic [WIDTH-1:0] d_next;
  logic             last;

  assign in_ready = (state == IDLE);

  // Operand registers shift right each RUN cycle, so the current slice is
  // always in bits [3:0]; subtraction is a + ~b + carry (carry = ~borrow).
  assign x = a_r[3:0];
  assign y = ~b_r[3:0];
  assign g = x & y;
  assign p = x ^ y;
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s    = p ^ c[3:0];
  assign last = (k == KW'(SLICES - 1));

  always_comb begin
    d_next = d;
    for (int i = 0; i < SLICES; i++) begin
      if (k == KW'(i)) d_next[i*4 +: 4] = s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r   <= a;
            b_r   <= b;
            carry <= ~bin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_r >> 4;
          b_r   <= b_r >> 4;
          carry <= c[4];
          d     <= d_next;
          k     <= k + KW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            bout      <= ~c[4];
            zero      <= (d_next == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_sub.sv
// Bench for cla_serial_sub (WIDTH=16): directed vectors, backpressure, reset
// abort, then randomised back-to-back traffic against a scoreboard queue.
module tb_cla_serial_sub;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];

  cla_serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .zero(zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {bout, zero, d} from plain 17-bit arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    logic [W:0] diff;
    diff = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    return {diff[W], (diff[W-1:0] == '0), diff[W-1:0]};
  endfunction

  task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vbin, input logic [W-1:0] ed, input logic eb,
                       input logic ez);
    int cyc;
    accept(va, vb, vbin);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, "_latency"}, cyc, 4);
    check({tag, "_d"}, d, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_zero"}, zero, ez);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_rise"}, in_ready, 1);
  endtask

  initial begin
    int cyc;
    int got;
    logic [W-1:0] hold_d;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_zero", zero, 0);
    rst_n = 1'b1;

    // directed vectors
    do_op("v1234", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    do_op("vunder", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    do_op("vbin", 16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0);
    do_op("veq", 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_op("vzbin", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // backpressure: hold result for 5 cycles while in_valid pulses
    accept(16'h8000, 16'h0001, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("bp_latency", cyc, 4);
    for (int i = 0; i < 5; i++) begin
      a = 16'h1111; b = 16'h2222; in_valid = i[0];
      @(posedge clk);
      #1;
      check("bp_d", d, 16'h7FFF);
      check("bp_bout", bout, 0);
      check("bp_zero", zero, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    in_valid = 1'b0;

    // reset mid-RUN
    accept(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_d", d, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // randomised back-to-back
    got = 0;
    fork
      begin : driver
        for (int i = 0; i < 1000; i++) begin
          logic [W-1:0] ra, rb;
          logic rbin;
          int wait_c;
          ra = W'($urandom_range(0, 16'hFFFF));
          rb = W'($urandom_range(0, 16'hFFFF));
          if (i % 7 == 0) rb = ra;
          rbin = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          @(negedge clk);
          a = ra; b = rb; bin = rbin; in_valid = 1'b1;
          wait_c = 0;
          while (!in_ready && wait_c < 200) begin
            @(negedge clk);
            wait_c++;
          end
          if (in_ready) exp_q.push_back(model(ra, rb, rbin));
          else check("rand_accept_timeout", 0, 1);
          @(posedge clk);
          #1 in_valid = 1'b0;
        end
      end
      begin : monitor
        int idle;
        logic [W+1:0] e;
        idle = 0;
        while (got < 1000 && idle < 400) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          idle++;
          if (out_valid && out_ready) begin
            idle = 0;
            if (exp_q.size() == 0) begin
              check("rand_unexpected_result", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("rand_d", d, e[W-1:0]);
              check("rand_bout", bout, e[W+1]);
              check("rand_zero", zero, e[W]);
            end
            got++;
          end
        end
        out_ready = 1'b0;
      end
    join
    check("rand_results_seen", got, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
